// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle FSM and its datapath.
// master = FSM side (drives controls), slave = datapath side.
interface multicycle_control_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       branch;
  logic       branch_ne;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_err;

  modport master (
    input  op, mem_ready,
    output pc_write, branch, branch_ne,
    output iord, mem_read, mem_write,
    output ir_write, reg_dst, mem_to_reg,
    output reg_write, alu_src_a, alu_src_b,
    output alu_op, pc_src, instr_done,
    output illegal_op, mem_err
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, branch, branch_ne,
    input  iord, mem_read, mem_write,
    input  ir_write, reg_dst, mem_to_reg,
    input  reg_write, alu_src_a, alu_src_b,
    input  alu_op, pc_src, instr_done,
    input  illegal_op, mem_err
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM with memory handshake and timeout trap.
// Define MC_CTRL_BNE_EN to decode opcode 5 (bne) as a branch.
module multicycle_control_fsm #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_control_fsm_if.master      bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam int CW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int unsigned LAST_I =
    (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_op_q;
  logic [CW-1:0] r_wait_cnt;

  logic w_in_mem;
  logic w_done;
  logic w_timeout;

  logic w_is_r;
  logic w_is_mem;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_imm;
  logic w_is_j;

  logic       w_pc_write;
  logic       w_branch;
  logic       w_branch_ne;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_src;
  logic       w_instr_done;
  logic       w_illegal_op;
  logic       w_mem_err;

  assign w_in_mem = (r_state == S_FETCH) ||
                    (r_state == S_MEMRD) ||
                    (r_state == S_MEMWR);

  assign w_done = ~MEM_HANDSHAKE | bus.mem_ready;

  // a completing access in the last allowed cycle beats the trap
  assign w_timeout = (MEM_TIMEOUT != 0) && w_in_mem &&
                     !w_done && (r_wait_cnt == CNT_LAST);

  assign w_is_r   = (bus.op == OP_R);
  assign w_is_mem = (bus.op == OP_LW) || (bus.op == OP_SW);
  assign w_is_beq = (bus.op == OP_BEQ);
  assign w_is_imm = (bus.op == OP_ADDI) || (bus.op == OP_ORI);
  assign w_is_j   = (bus.op == OP_J);
`ifdef MC_CTRL_BNE_EN
  assign w_is_bne = (bus.op == OP_BNE);
`else
  assign w_is_bne = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_op_q     <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE)
        r_op_q <= bus.op;
      if (w_state_nxt != r_state)
        r_wait_cnt <= '0;
      else if ((MEM_TIMEOUT != 0) && w_in_mem && !w_done)
        r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_branch_ne  = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 2'b00;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    w_mem_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (w_done) begin
          w_ir_write  = 1'b1;
          w_pc_write  = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        unique case (1'b1)
          w_is_r:             w_state_nxt = S_EXEC;
          w_is_mem:           w_state_nxt = S_MEMADR;
          w_is_beq, w_is_bne: w_state_nxt = S_BRANCH;
          w_is_imm:           w_state_nxt = S_IEXEC;
          w_is_j:             w_state_nxt = S_JUMP;
          default: begin
            w_illegal_op = 1'b1;
            w_instr_done = 1'b1;
            w_state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_state_nxt = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (w_done)
          w_state_nxt = S_MEMWB;
        else if (w_timeout)
          w_state_nxt = S_TRAP;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (w_done) begin
          w_instr_done = 1'b1;
          w_state_nxt  = S_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b01;
        w_pc_src     = 2'b01;
        w_instr_done = 1'b1;
        w_branch     = (r_op_q == OP_BEQ);
`ifdef MC_CTRL_BNE_EN
        w_branch_ne  = (r_op_q == OP_BNE);
`endif
        w_state_nxt  = S_FETCH;
      end
      S_IEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = (r_op_q == OP_ORI) ? 2'b11 : 2'b00;
        w_state_nxt = S_IWB;
      end
      S_IWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_TRAP: begin
        w_mem_err = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // reset aborts the instruction: nothing may strobe this cycle
  assign bus.pc_write   = w_pc_write   & ~rst;
  assign bus.branch     = w_branch     & ~rst;
  assign bus.branch_ne  = w_branch_ne  & ~rst;
  assign bus.iord       = w_iord       & ~rst;
  assign bus.mem_read   = w_mem_read   & ~rst;
  assign bus.mem_write  = w_mem_write  & ~rst;
  assign bus.ir_write   = w_ir_write   & ~rst;
  assign bus.reg_dst    = w_reg_dst    & ~rst;
  assign bus.mem_to_reg = w_mem_to_reg & ~rst;
  assign bus.reg_write  = w_reg_write  & ~rst;
  assign bus.alu_src_a  = w_alu_src_a  & ~rst;
  assign bus.alu_src_b  = w_alu_src_b  & {2{~rst}};
  assign bus.alu_op     = w_alu_op     & {2{~rst}};
  assign bus.pc_src     = w_pc_src     & {2{~rst}};
  assign bus.instr_done = w_instr_done & ~rst;
  assign bus.illegal_op = w_illegal_op & ~rst;
  assign bus.mem_err    = w_mem_err    & ~rst;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle scripts
// built from opcode rules, replayed with random waits and resets.
module tb_multicycle_control_fsm;

  localparam bit          HS = 1'b1;
  localparam int unsigned TO = 15;

  localparam logic [19:0] PCW  = 20'h1 << 19;
  localparam logic [19:0] BR   = 20'h1 << 18;
  localparam logic [19:0] BNE  = 20'h1 << 17;
  localparam logic [19:0] IORD = 20'h1 << 16;
  localparam logic [19:0] MR   = 20'h1 << 15;
  localparam logic [19:0] MW   = 20'h1 << 14;
  localparam logic [19:0] IRW  = 20'h1 << 13;
  localparam logic [19:0] RD   = 20'h1 << 12;
  localparam logic [19:0] M2R  = 20'h1 << 11;
  localparam logic [19:0] RW   = 20'h1 << 10;
  localparam logic [19:0] ASA  = 20'h1 << 9;
  localparam logic [19:0] DONE = 20'h1 << 2;
  localparam logic [19:0] ILL  = 20'h1 << 1;
  localparam logic [19:0] ERR  = 20'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(
    .MEM_HANDSHAKE(HS),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          rs;
    bit          rdy;
    logic [5:0]  op;
    logic [19:0] exp;
    string       tag;
  } step_t;

  step_t q[$];

  function automatic logic [19:0] asb(input logic [1:0] v);
    return {11'd0, v, 7'd0};
  endfunction

  function automatic logic [19:0] aop(input logic [1:0] v);
    return {13'd0, v, 5'd0};
  endfunction

  function automatic logic [19:0] psrc(input logic [1:0] v);
    return {15'd0, v, 3'd0};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit legal(input logic [5:0] op);
    bit bne_ok;
`ifdef MC_CTRL_BNE_EN
    bne_ok = 1'b1;
`else
    bne_ok = 1'b0;
`endif
    if (op == 6'd5) return bne_ok;
    return op inside {6'd0, 6'd2, 6'd4, 6'd8,
                      6'd13, 6'd35, 6'd43};
  endfunction

  function automatic void push(input bit rs, input bit rdy,
                               input logic [5:0] op,
                               input logic [19:0] e,
                               input string tag);
    step_t s;
    s.rs  = rs;
    s.rdy = rdy;
    s.op  = op;
    s.exp = e;
    s.tag = tag;
    q.push_back(s);
  endfunction

  function automatic void mem_phase(input logic [19:0] we,
                                    input logic [19:0] de,
                                    input int waits,
                                    input string tag,
                                    output bit trapped);
    if (TO != 0 && waits >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++)
        push(1'b0, 1'b0, rop(), we, {tag, "_wait"});
      for (int i = 0; i < 3; i++)
        push(1'b0, 1'($urandom), rop(), ERR, "trap");
      push(1'b1, 1'($urandom), rop(), 20'h0, "trap_rst");
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++)
        push(1'b0, 1'b0, rop(), we, {tag, "_wait"});
      push(1'b0, 1'b1, rop(), de, tag);
      trapped = 1'b0;
    end
  endfunction

  function automatic void gen_instr(input logic [5:0] op,
                                    input int fw,
                                    input int mw);
    bit t;
    mem_phase(MR | asb(2'b01), MR | asb(2'b01) | IRW | PCW,
              fw, "fetch", t);
    if (t) return;
    if (!legal(op)) begin
      push(1'b0, 1'($urandom), op, asb(2'b11) | DONE | ILL,
           "decode_ill");
      return;
    end
    push(1'b0, 1'($urandom), op, asb(2'b11), "decode");
    case (op)
      6'd0: begin
        push(1'b0, 1'($urandom), rop(), ASA | aop(2'b10), "exec");
        push(1'b0, 1'($urandom), rop(), RD | RW | DONE, "aluwb");
      end
      6'd35: begin
        push(1'b0, 1'($urandom), rop(), ASA | asb(2'b10), "memadr");
        mem_phase(IORD | MR, IORD | MR, mw, "memrd", t);
        if (!t)
          push(1'b0, 1'($urandom), rop(), M2R | RW | DONE, "memwb");
      end
      6'd43: begin
        push(1'b0, 1'($urandom), rop(), ASA | asb(2'b10), "memadr");
        mem_phase(IORD | MW, IORD | MW | DONE, mw, "memwr", t);
      end
      6'd4, 6'd5: begin
        push(1'b0, 1'($urandom), rop(),
             ASA | aop(2'b01) | psrc(2'b01) | DONE |
             ((op == 6'd4) ? BR : BNE), "branch");
      end
      6'd8, 6'd13: begin
        push(1'b0, 1'($urandom), rop(),
             ASA | asb(2'b10) |
             aop((op == 6'd13) ? 2'b11 : 2'b00), "iexec");
        push(1'b0, 1'($urandom), rop(), RW | DONE, "iwb");
      end
      6'd2: begin
        push(1'b0, 1'($urandom), rop(),
             psrc(2'b10) | PCW | DONE, "jump");
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [19:0] got,
                     input logic [19:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] observed();
    return {bus.pc_write, bus.branch, bus.branch_ne,
            bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_dst, bus.mem_to_reg,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.instr_done,
            bus.illegal_op, bus.mem_err};
  endfunction

  task automatic run_queue();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      rst           = s.rs;
      bus.mem_ready = s.rdy;
      bus.op        = s.op;
      #1;
      chk($sformatf("%s@%0d", s.tag, cyc), observed(), s.exp);
      cyc++;
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int         fw, mw, qs, k;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd13, 6'd2, 6'd5};
    bus.op        = 6'd0;
    bus.mem_ready = 1'b1;

    push(1'b1, 1'b1, 6'd0, 20'h0, "reset");
    push(1'b1, 1'b1, 6'd0, 20'h0, "reset");
    gen_instr(6'd0, 0, 0);
    gen_instr(6'd35, 0, 3);
    gen_instr(6'd43, 0, 100);
    gen_instr(6'd5, 0, 0);
    gen_instr(6'd2, 0, 0);
    gen_instr(6'd13, 0, 0);
    gen_instr(6'd8, 2, 0);
    gen_instr(6'd4, 0, 0);
    gen_instr(6'd35, 100, 0);
    run_queue();

    repeat (400) begin
      if ($urandom_range(9) < 7)
        op = ops[$urandom_range(7)];
      else
        op = rop();
      fw = ($urandom_range(29) == 0) ? 14 + $urandom_range(2)
                                     : $urandom_range(3);
      mw = ($urandom_range(19) == 0) ? 14 + $urandom_range(2)
                                     : $urandom_range(4);
      qs = q.size();
      gen_instr(op, fw, mw);
      if ($urandom_range(9) == 0) begin
        k = qs + $urandom_range(q.size() - qs - 1);
        while (q.size() > k) void'(q.pop_back());
        push(1'b1, 1'($urandom), rop(), 20'h0, "abort_rst");
      end
      run_queue();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
